// File: rtl/ps2_key_if.sv
// Bus between the PS/2 key controller and its host: raw keyboard lines,
// the event FIFO read side and status.
//
// Handshake: an event is offered while ev_valid=1, with ev_code/ev_ext/ev_break
// stable at the FIFO head. It is consumed on a rising clk edge where rd_en=1 and
// ev_valid=1. The next head appears in the following cycle. rd_en while
// ev_valid=0 is ignored.
interface ps2_key_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       clr_ovf;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       overflow;
    logic       frame_err;
    logic [1:0] dbg_state;  // frame FSM state, for observation only

    modport master (
        output ps2_clk, ps2_data, rd_en, clr_ovf,
        input  ev_valid, ev_code, ev_ext, ev_break, overflow, frame_err, dbg_state
    );

    modport slave (
        input  ps2_clk, ps2_data, rd_en, clr_ovf,
        output ev_valid, ev_code, ev_ext, ev_break, overflow, frame_err, dbg_state
    );
endinterface

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver: synchronises the raw lines, decodes 11-bit frames
// with odd parity and a frame timeout, folds E0/F0 prefixes into one event and
// queues events in a first-word fall-through FIFO.
module ps2_key_controller #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic     clk,
    input  logic     rst,
    ps2_key_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Synchroniser and edge detector
    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fall;

    // Frame receiver
    frame_state_t state;
    logic [2:0]   bitcnt;
    logic [7:0]   shreg;
    logic         par_ok;
    logic         byte_rdy;
    logic         frame_err;
    logic [TW-1:0] tcnt;

    // Prefix tracking and FIFO
    logic          ext, brk;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic          push_req, do_push, pop, full, ev_valid;

    // Two-flop synchronisers; idle-high lines so reset to 1 avoids a false fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= bus.ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= bus.ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // Frame FSM: steps on each keyboard clock fall, abandons a stalled frame on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par_ok    <= 1'b0;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
            tcnt      <= '0;
        end else begin
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
            if (fall)
                tcnt <= '0;
            else if (state != ST_IDLE)
                tcnt <= tcnt + 1'b1;

            if (!fall && state != ST_IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                tcnt      <= '0;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        // A high level at a fall is a glitch, not a start bit
                        if (!data_s2) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg[bitcnt] <= data_s2;
                        if (bitcnt == 3'd7)
                            state <= ST_PARITY;
                        bitcnt <= bitcnt + 1'b1;
                    end
                    ST_PARITY: begin
                        par_ok <= ^{data_s2, shreg};
                        state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (data_s2 && par_ok)
                            byte_rdy <= 1'b1;
                        else
                            frame_err <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign push_req = byte_rdy && (shreg != 8'hE0) && (shreg != 8'hF0);
    assign ev_valid = (count != '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = bus.rd_en && ev_valid;
    assign do_push  = push_req && (!full || pop);

    // Prefix flags, FIFO pointers/count and sticky overflow (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext      <= 1'b0;
            brk      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_rdy) begin
                if (shreg == 8'hE0)
                    ext <= 1'b1;
                else if (shreg == 8'hF0)
                    brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end

            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (bus.clr_ovf)
                overflow <= 1'b0;
        end
    end

    // Event storage; contents are don't-care until written, outputs are gated below
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {ext, brk, shreg};
    end

    assign bus.ev_valid  = ev_valid;
    assign bus.ev_code   = ev_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign bus.ev_break  = ev_valid ? mem[rd_ptr][8]   : 1'b0;
    assign bus.ev_ext    = ev_valid ? mem[rd_ptr][9]   : 1'b0;
    assign bus.overflow  = overflow;
    assign bus.frame_err = frame_err;
    assign bus.dbg_state = state;
endmodule
